traffic_intersection_ctrl: RTL and testbench
============================================

TRAFFIC_INTERSECTION_CTRL -- requirements
Module: traffic_intersection_ctrl

Interface
REQ-001 Parameter TMR_W, default 8, phase timer width in bits.
REQ-002 Parameter GREEN_CYC, default 20, green phase length in clk cycles.
REQ-003 Parameter YELLOW_CYC, default 4, yellow phase length in cycles.
REQ-004 Parameter ALLRED_CYC, default 2, all-red clearance length in cycles.
REQ-005 Parameter WALK_CYC, default 10, pedestrian walk phase length in cycles.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 ped_req  in  1  pedestrian button, level, sampled every cycle.
REQ-009 car_ew  in  1  vehicle present on EW approach.
REQ-010 light_ns  out  2  NS lamp: 00=Red, 01=Yellow, 10=Green.
REQ-011 light_ew  out  2  EW lamp, same encoding.
REQ-012 walk  out  1  all-way pedestrian walk.
REQ-013 ped_pend  out  1  pedestrian request latched, not yet served.
REQ-014 state_o  out  3  current FSM state code.

Function
REQ-015 FSM states and codes: NS_G=0, NS_Y=1, RED_A=2, EW_G=3, EW_Y=4, RED_B=5, WALK=6; code 7 unused and SHALL recover to RED_B next cycle.
REQ-016 Lamps and walk decode combinationally from the state register (Moore): NS_G gives light_ns=10, NS_Y gives 01, EW_G gives light_ew=10, EW_Y gives 01; all other lamp values 00; walk=1 only in WALK.
REQ-017 Down-counter timer loads (phase_CYC-1) on state entry, decrements each cycle, and the phase ends in the cycle the timer reads 0; each phase lasts exactly its CYC count.
REQ-018 NS_G at timer 0: go to NS_Y if car_ew=1 or ped_pend=1, else stay NS_G with timer reloaded (green extension).
REQ-019 NS_Y -> RED_A; EW_G -> EW_Y unconditionally; EW_Y -> RED_B.
REQ-020 RED_A at timer 0: go to WALK if ped_pend=1, else EW_G; RED_B at timer 0: go to WALK if ped_pend=1, else NS_G.
REQ-021 1-bit dir register records the next green (EW after RED_A, NS after RED_B); WALK at timer 0 goes to EW_G if dir=EW, else NS_G.
REQ-022 ped_pend sets on any cycle with ped_req=1, clears on the cycle the FSM enters WALK; ped_req high on that entry cycle or during WALK SHALL leave ped_pend=0 (absorbed).
REQ-023 Lamps SHALL never show green or yellow on both approaches at once; walk=1 only while both lamps are 00.
REQ-024 Every parameter value SHALL be >=1 and <=2^TMR_W; violation is a static error (elaboration assertion).

Reset
REQ-025 rst=1 at a rising edge forces state NS_G, timer=GREEN_CYC-1, dir=EW, ped_pend=0; outputs SHALL read light_ns=10, light_ew=00, walk=0, ped_pend=0, state_o=0.
REQ-026 rst asserted mid-phase (including WALK or yellow) SHALL abort immediately at the next edge with no intermediate yellow or red.
REQ-027 rst has priority over ped_req, car_ew and emg.

Configuration
REQ-028 Macro EMERGENCY_PREEMPT_EN, when defined, adds input emg (1 bit) and state PRE=7, replacing the code-7 recovery of REQ-015.
REQ-029 With macro: emg=1 in NS_G/EW_G forces the matching yellow next cycle (full YELLOW_CYC); emg=1 in any other state forces PRE after the current yellow or all-red completes, WALK aborting immediately; PRE is all-red, walk=0, held while emg=1; emg low in PRE loads ALLRED_CYC then goes to NS_G; ped_pend is retained throughout.
REQ-030 Without macro: no emg port, no PRE state, behaviour per REQ-015..024 exactly.

Verification
REQ-031 rst 1 cycle, car_ew=0, ped_req=0, 100 cycles -> light_ns=10 continuously, light_ew=00.
REQ-032 car_ew=1 held -> NS_G 20, NS_Y 4, RED_A 2, EW_G 20, EW_Y 4, RED_B 2 cycles, repeating period 52.
REQ-033 ped_req 1-cycle pulse during NS_G, car_ew=0 -> ped_pend=1 next cycle; NS_Y, RED_A, then WALK 10 cycles walk=1, then EW_G; ped_pend=0 from WALK entry.
REQ-034 ped_req held high through WALK entry -> ped_pend stays 0 after entry, no second WALK unless pressed again after WALK.
REQ-035 rst asserted in 3rd WALK cycle -> next cycle state_o=0, light_ns=10, walk=0.
REQ-036 (EMERGENCY_PREEMPT_EN) emg=1 in EW_G cycle 5 -> EW_Y 4 cycles, RED_B 2 cycles, PRE while emg=1; emg=0 -> 2 all-red cycles, then NS_G.

Source files
------------

// File: rtl/traffic_intersection_ctrl.sv
// traffic_intersection_ctrl
//   Two-approach (NS / EW) intersection controller with an all-way
//   pedestrian walk phase. Moore FSM: lamps and walk decode from the state
//   register only. A per-phase down-counter sets each phase length. NS green
//   is extended while no EW vehicle and no pending pedestrian is waiting.
//
// Optional feature (macro EMERGENCY_PREEMPT_EN):
//   Adds input emg and state PRE (code 7). Greens yield through a full yellow.
//   Yellow and all-red phases finish normally, then enter PRE. WALK aborts
//   straight to PRE. PRE holds all-red while emg=1. It then runs one
//   ALLRED_CYC clearance and returns to NS green. Without the macro, code 7 is
//   unused and recovers to RED_B.
//
// Ports:
//   clk       in   sole clock, rising edge
//   rst       in   synchronous active-high reset
//   ped_req   in   pedestrian button (level, sampled every cycle)
//   car_ew    in   vehicle present on the EW approach
//   emg       in   emergency preemption request (only with EMERGENCY_PREEMPT_EN)
//   light_ns  out  NS lamp, 00=Red 01=Yellow 10=Green
//   light_ew  out  EW lamp, same encoding
//   walk      out  all-way pedestrian walk
//   ped_pend  out  pedestrian request latched and not yet served
//   state_o   out  current FSM state code
module traffic_intersection_ctrl #(
  parameter int TMR_W      = 8,
  parameter int GREEN_CYC  = 20,
  parameter int YELLOW_CYC = 4,
  parameter int ALLRED_CYC = 2,
  parameter int WALK_CYC   = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ped_req,
  input  logic       car_ew,
`ifdef EMERGENCY_PREEMPT_EN
  input  logic       emg,
`endif
  output logic [1:0] light_ns,
  output logic [1:0] light_ew,
  output logic       walk,
  output logic       ped_pend,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    RED_A = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    RED_B = 3'd5,
    WALK  = 3'd6
`ifdef EMERGENCY_PREEMPT_EN
    , PRE = 3'd7
`endif
  } state_t;

  localparam logic [1:0] LAMP_RED    = 2'b00;
  localparam logic [1:0] LAMP_YELLOW = 2'b01;
  localparam logic [1:0] LAMP_GREEN  = 2'b10;

  // dir remembers which approach gets green after a walk phase.
  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  // Parameter range checks, evaluated at elaboration time.
  localparam longint MAX_CYC = longint'(1) << TMR_W;

  if (TMR_W < 1 || TMR_W > 32) begin : g_bad_tmr_w
    $error("traffic_intersection_ctrl: TMR_W out of range");
  end
  if (GREEN_CYC < 1 || longint'(GREEN_CYC) > MAX_CYC) begin : g_bad_green
    $error("traffic_intersection_ctrl: GREEN_CYC out of range");
  end
  if (YELLOW_CYC < 1 || longint'(YELLOW_CYC) > MAX_CYC) begin : g_bad_yellow
    $error("traffic_intersection_ctrl: YELLOW_CYC out of range");
  end
  if (ALLRED_CYC < 1 || longint'(ALLRED_CYC) > MAX_CYC) begin : g_bad_allred
    $error("traffic_intersection_ctrl: ALLRED_CYC out of range");
  end
  if (WALK_CYC < 1 || longint'(WALK_CYC) > MAX_CYC) begin : g_bad_walk
    $error("traffic_intersection_ctrl: WALK_CYC out of range");
  end

  // Timer reload values: a phase of N cycles counts N-1 down to 0.
  localparam logic [TMR_W-1:0] LD_GREEN  = TMR_W'(GREEN_CYC - 1);
  localparam logic [TMR_W-1:0] LD_YELLOW = TMR_W'(YELLOW_CYC - 1);
  localparam logic [TMR_W-1:0] LD_ALLRED = TMR_W'(ALLRED_CYC - 1);
  localparam logic [TMR_W-1:0] LD_WALK   = TMR_W'(WALK_CYC - 1);

  state_t           state;
  state_t           state_nxt;
  logic [TMR_W-1:0] timer;
  logic             reload;
  logic             dir;
  logic             tmr_zero;

  assign tmr_zero = (timer == '0);

  function automatic logic [TMR_W-1:0] phase_load(input state_t s);
    case (s)
      NS_G, EW_G: phase_load = LD_GREEN;
      NS_Y, EW_Y: phase_load = LD_YELLOW;
      WALK:       phase_load = LD_WALK;
      default:    phase_load = LD_ALLRED;  // RED_A, RED_B and PRE
    endcase
  endfunction

  // Next-state logic.
  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    reload    = 1'b0;
    case (state)
      NS_G: begin
`ifdef EMERGENCY_PREEMPT_EN
        if (emg) state_nxt = NS_Y;
        else
`endif
        if (tmr_zero) begin
          if (car_ew || ped_pend) state_nxt = NS_Y;
          else                    reload    = 1'b1;  // green extension
        end
      end
      NS_Y: if (tmr_zero) state_nxt = RED_A;
      RED_A: begin
        if (tmr_zero) begin
`ifdef EMERGENCY_PREEMPT_EN
          if (emg) state_nxt = PRE;
          else
`endif
          if (ped_pend) state_nxt = WALK;
          else          state_nxt = EW_G;
        end
      end
      EW_G: begin
`ifdef EMERGENCY_PREEMPT_EN
        if (emg) state_nxt = EW_Y;
        else
`endif
        if (tmr_zero) state_nxt = EW_Y;
      end
      EW_Y: if (tmr_zero) state_nxt = RED_B;
      RED_B: begin
        if (tmr_zero) begin
`ifdef EMERGENCY_PREEMPT_EN
          if (emg) state_nxt = PRE;
          else
`endif
          if (ped_pend) state_nxt = WALK;
          else          state_nxt = NS_G;
        end
      end
      WALK: begin
`ifdef EMERGENCY_PREEMPT_EN
        if (emg) state_nxt = PRE;
        else
`endif
        if (tmr_zero) state_nxt = (dir == DIR_EW) ? EW_G : NS_G;
      end
`ifdef EMERGENCY_PREEMPT_EN
      PRE: begin
        // Clearance timer stays parked at full length until emg drops.
        if (emg)           reload    = 1'b1;
        else if (tmr_zero) state_nxt = NS_G;
      end
`endif
      default: state_nxt = RED_B;  // unused code recovers to a safe all-red
    endcase
  end

  // NOTE: the reset branch lives inside the clocked block, so reset is
  // synchronous and only takes effect on a rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= NS_G;
      timer    <= LD_GREEN;
      dir      <= DIR_EW;
      ped_pend <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values, regardless of statement order.
      state <= state_nxt;

      if (state_nxt != state || reload) timer <= phase_load(state_nxt);
      else                              timer <= timer - TMR_W'(1);

      if (state == RED_A)      dir <= DIR_EW;
      else if (state == RED_B) dir <= DIR_NS;

      // A press on the cycle WALK is entered, or during WALK, is served by
      // that walk and is not latched again.
      if (state_nxt == WALK || state == WALK) ped_pend <= 1'b0;
      else if (ped_req)                       ped_pend <= 1'b1;
    end
  end

  // Moore output decode.
  always_comb begin
    light_ns = LAMP_RED;
    light_ew = LAMP_RED;
    walk     = 1'b0;
    case (state)
      NS_G:    light_ns = LAMP_GREEN;
      NS_Y:    light_ns = LAMP_YELLOW;
      EW_G:    light_ew = LAMP_GREEN;
      EW_Y:    light_ew = LAMP_YELLOW;
      WALK:    walk     = 1'b1;
      default: ;
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Directed self-checking bench for traffic_intersection_ctrl (default
// parameters). Expected values are hand-derived from the phase lengths
// G=20, Y=4, AR=2, W=10. Sample index k counts falling edges after the
// reset edge; k=0 is the first cycle of NS green.
module tb_traffic_intersection_ctrl;

  localparam int G   = 20;
  localparam int Y   = 4;
  localparam int AR  = 2;
  localparam int PER = 2 * (G + Y + AR);  // 52

  logic       clk = 1'b0;
  logic       rst;
  logic       ped_req;
  logic       car_ew;
`ifdef EMERGENCY_PREEMPT_EN
  logic       emg;
`endif
  logic [1:0] light_ns;
  logic [1:0] light_ew;
  logic       walk;
  logic       ped_pend;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;

  traffic_intersection_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .ped_req  (ped_req),
    .car_ew   (car_ew),
`ifdef EMERGENCY_PREEMPT_EN
    .emg      (emg),
`endif
    .light_ns (light_ns),
    .light_ew (light_ew),
    .walk     (walk),
    .ped_pend (ped_pend),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Called at a falling edge; returns at the falling edge after the reset edge.
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Lamp-safety invariants, checked alongside the cycle traces.
  task automatic check_safe();
    check("lamp_excl", 8'((light_ns != 2'b00) && (light_ew != 2'b00)), 8'd0);
    check("walk_red",  8'(walk && ((light_ns != 2'b00) || (light_ew != 2'b00))), 8'd0);
  endtask

  // Expected state for the free-running car_ew=1 cycle.
  function automatic logic [2:0] cyc_state(input int k);
    int p;
    p = k % PER;
    if (p < G)                   return 3'd0;
    else if (p < G + Y)          return 3'd1;
    else if (p < G + Y + AR)     return 3'd2;
    else if (p < 2*G + Y + AR)   return 3'd3;
    else if (p < 2*G + 2*Y + AR) return 3'd4;
    else                         return 3'd5;
  endfunction

  function automatic logic [1:0] exp_ns(input logic [2:0] s);
    return (s == 3'd0) ? 2'b10 : (s == 3'd1) ? 2'b01 : 2'b00;
  endfunction

  function automatic logic [1:0] exp_ew(input logic [2:0] s);
    return (s == 3'd3) ? 2'b10 : (s == 3'd4) ? 2'b01 : 2'b00;
  endfunction

  initial begin
    rst     = 1'b1;
    ped_req = 1'b0;
    car_ew  = 1'b0;
`ifdef EMERGENCY_PREEMPT_EN
    emg     = 1'b0;
`endif

    // Reset values.
    do_reset();
    check("rst_state",    8'(state_o),  8'd0);
    check("rst_light_ns", 8'(light_ns), 8'h2);
    check("rst_light_ew", 8'(light_ew), 8'h0);
    check("rst_walk",     8'(walk),     8'd0);
    check("rst_ped_pend", 8'(ped_pend), 8'd0);

    // No demand: NS stays green for 100 cycles.
    for (int k = 0; k < 100; k++) begin
      check("idle_ns", 8'(light_ns), 8'h2);
      check("idle_ew", 8'(light_ew), 8'h0);
      tick();
    end

    // Continuous EW demand: full 52-cycle rotation, two periods.
    do_reset();
    car_ew = 1'b1;
    for (int k = 0; k < 2 * PER; k++) begin
      check("cyc_state", 8'(state_o),  8'(cyc_state(k)));
      check("cyc_ns",    8'(light_ns), 8'(exp_ns(cyc_state(k))));
      check("cyc_ew",    8'(light_ew), 8'(exp_ew(cyc_state(k))));
      check("cyc_walk",  8'(walk),     8'd0);
      check_safe();
      tick();
    end
    car_ew = 1'b0;

    // Single pedestrian pulse during NS green.
    do_reset();
    repeat (5) tick();
    ped_req = 1'b1;
    tick();                                   // k=6
    ped_req = 1'b0;
    check("pulse_pend_set", 8'(ped_pend), 8'd1);
    repeat (13) tick();                       // k=19
    check("pulse_ns_g_end", 8'(state_o), 8'd0);
    tick();                                   // k=20
    check("pulse_ns_y",     8'(state_o), 8'd1);
    repeat (4) tick();                        // k=24
    check("pulse_red_a",    8'(state_o), 8'd2);
    check("pulse_pend_red", 8'(ped_pend), 8'd1);
    repeat (2) tick();                        // k=26
    check("walk_state",     8'(state_o),  8'd6);
    check("walk_on",        8'(walk),     8'd1);
    check("walk_pend_clr",  8'(ped_pend), 8'd0);
    check_safe();
    repeat (9) tick();                        // k=35
    check("walk_last",      8'(state_o), 8'd6);
    check("walk_last_on",   8'(walk),    8'd1);
    tick();                                   // k=36
    check("post_walk_state", 8'(state_o),  8'd3);
    check("post_walk_off",   8'(walk),     8'd0);
    check("post_walk_ew",    8'(light_ew), 8'h2);
    check("post_walk_ns",    8'(light_ns), 8'h0);

    // Button held through walk entry is absorbed.
    do_reset();
    repeat (5) tick();
    ped_req = 1'b1;
    tick();                                   // k=6
    check("hold_pend_set", 8'(ped_pend), 8'd1);
    repeat (19) tick();                       // k=25
    check("hold_red_a",    8'(state_o),  8'd2);
    tick();                                   // k=26
    check("hold_walk",     8'(state_o),  8'd6);
    check("hold_pend_26",  8'(ped_pend), 8'd0);
    tick();                                   // k=27
    check("hold_pend_27",  8'(ped_pend), 8'd0);
    tick();                                   // k=28
    check("hold_pend_28",  8'(ped_pend), 8'd0);
    ped_req = 1'b0;
    tick();                                   // k=29
    check("hold_pend_29",  8'(ped_pend), 8'd0);
    repeat (7) tick();                        // k=36
    check("hold_ew_g",     8'(state_o),  8'd3);
    check("hold_pend_36",  8'(ped_pend), 8'd0);
    repeat (24) tick();                       // k=60
    check("hold_red_b",    8'(state_o),  8'd5);
    repeat (2) tick();                        // k=62
    check("hold_no_walk2", 8'(state_o),  8'd0);

    // Reset in the third WALK cycle aborts immediately.
    do_reset();
    repeat (5) tick();
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    repeat (22) tick();                       // k=28
    check("abort_in_walk", 8'(state_o), 8'd6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_state", 8'(state_o),  8'd0);
    check("abort_ns",    8'(light_ns), 8'h2);
    check("abort_ew",    8'(light_ew), 8'h0);
    check("abort_walk",  8'(walk),     8'd0);
    check("abort_pend",  8'(ped_pend), 8'd0);
    tick();
    check("abort_hold",  8'(state_o),  8'd0);

`ifdef EMERGENCY_PREEMPT_EN
    // Emergency during EW green.
    do_reset();
    car_ew = 1'b1;
    repeat (30) tick();                       // k=30, EW_G
    check("emg_ew_g", 8'(state_o), 8'd3);
    emg = 1'b1;
    tick();                                   // k=31
    check("emg_ew_y",  8'(state_o), 8'd4);
    repeat (3) tick();                        // k=34
    check("emg_ew_y4", 8'(state_o), 8'd4);
    tick();                                   // k=35
    check("emg_red_b", 8'(state_o), 8'd5);
    repeat (2) tick();                        // k=37
    check("emg_pre",   8'(state_o), 8'd7);
    repeat (3) tick();                        // k=40
    check("emg_pre_hold", 8'(state_o), 8'd7);
    emg = 1'b0;
    tick();                                   // k=41
    check("emg_pre_clr", 8'(state_o), 8'd7);
    tick();                                   // k=42
    check("emg_ns_g",    8'(state_o), 8'd0);
    car_ew = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
